// File: rtl/cmult_dot_ctrl.sv
// Sequences one LEN-element complex dot product through a shared cmult and accumulates with saturation.
// Latency: result valid LEN+MULT_LAT edges after the input handshake; one vector in flight at a time.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready, stalling new input.
module cmult_dot_ctrl #(
    parameter int Q        = 8,
    parameter int N        = 16,
    parameter int LEN      = 4,
    parameter int MULT_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LEN*N-1:0] h_r,
    input  logic [LEN*N-1:0] h_i,
    input  logic [LEN*N-1:0] s_r,
    input  logic [LEN*N-1:0] s_i,
    output logic [N-1:0]     ar,
    output logic [N-1:0]     ai,
    output logic [N-1:0]     br,
    output logic [N-1:0]     bi,
    input  logic [N-1:0]     pr,
    input  logic [N-1:0]     pi,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     y_r,
    output logic [N-1:0]     y_i,
    output logic             ovf,
    output logic             busy
);

    localparam int AW = N + $clog2(LEN);
    localparam int KW = $clog2(LEN);
    localparam int OW = (LEN - 1) * N;

    // Q only matters to cmult; it is checked here so a bad build fails early.
    if (LEN < 2 || MULT_LAT < 1 || Q >= N) begin : g_param_check
        $error("cmult_dot_ctrl: need LEN>=2, MULT_LAT>=1, Q<N");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t          state_q, state_d;
    // Element 0 goes straight from the input port to ar..bi, so only 1..LEN-1 are stored.
    logic [OW-1:0]   op_hr, op_hi, op_sr, op_si;
    logic [KW-1:0]   issue_k;
    logic [KW-1:0]   prod_k;
    // One stage for the ar..bi register plus MULT_LAT stages inside cmult.
    logic [MULT_LAT:0] tag_sr;
    logic [AW-1:0]   acc_r, acc_i;

    logic            accept, issue_now, prod_vld, prod_last;
    logic [N-1:0]    nx_ar, nx_ai, nx_br, nx_bi;
    logic [AW-1:0]   add_r, add_i, sum_r, sum_i;
    logic [N:0]      sat_r, sat_i;

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_ready && in_valid;
    assign issue_now = accept || (state_q == ISSUE);
    assign prod_vld  = tag_sr[MULT_LAT];
    assign prod_last = prod_vld && (prod_k == KW'(LEN - 1));

    // Clip to the signed N-bit range; MSB of the return is the clip flag.
    function automatic logic [N:0] saturate(input logic [AW-1:0] v);
        logic [AW-N:0] top;
        top = v[AW-1:N-1];
        if (top == '0 || top == '1)
            return {1'b0, v[N-1:0]};
        else if (v[AW-1])
            return {1'b1, 1'b1, {(N-1){1'b0}}};
        else
            return {1'b1, 1'b0, {(N-1){1'b1}}};
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)                     state_d = ISSUE;
            ISSUE:   if (issue_k == KW'(LEN - 1))      state_d = DRAIN;
            DRAIN:   if (prod_last)                    state_d = DONE;
            DONE:    if (out_ready)                    state_d = IDLE;
            default:                                   state_d = IDLE;
        endcase
    end

    // Pick the element to present to cmult next; zero whenever nothing is issued.
    always_comb begin
        nx_ar = '0;
        nx_ai = '0;
        nx_br = '0;
        nx_bi = '0;
        if (accept) begin
            nx_ar = h_r[LEN*N-1 -: N];
            nx_ai = h_i[LEN*N-1 -: N];
            nx_br = s_r[LEN*N-1 -: N];
            nx_bi = s_i[LEN*N-1 -: N];
        end else if (state_q == ISSUE) begin
            nx_ar = op_hr[(LEN - 1 - int'(issue_k)) * N +: N];
            nx_ai = op_hi[(LEN - 1 - int'(issue_k)) * N +: N];
            nx_br = op_sr[(LEN - 1 - int'(issue_k)) * N +: N];
            nx_bi = op_si[(LEN - 1 - int'(issue_k)) * N +: N];
        end
    end

    // Sign-extend the returned product; the first product of a vector replaces the old sum.
    always_comb begin
        add_r = {{(AW-N){pr[N-1]}}, pr};
        add_i = {{(AW-N){pi[N-1]}}, pi};
        sum_r = (prod_k == '0) ? add_r : acc_r + add_r;
        sum_i = (prod_k == '0) ? add_i : acc_i + add_i;
        sat_r = saturate(sum_r);
        sat_i = saturate(sum_i);
    end

    // Operand latch, issue counter, multiplier operands and tag pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_hr   <= '0;
            op_hi   <= '0;
            op_sr   <= '0;
            op_si   <= '0;
            issue_k <= '0;
            ar      <= '0;
            ai      <= '0;
            br      <= '0;
            bi      <= '0;
            tag_sr  <= '0;
        end else begin
            ar     <= nx_ar;
            ai     <= nx_ai;
            br     <= nx_br;
            bi     <= nx_bi;
            tag_sr <= {tag_sr[MULT_LAT-1:0], issue_now};
            if (accept) begin
                op_hr   <= h_r[OW-1:0];
                op_hi   <= h_i[OW-1:0];
                op_sr   <= s_r[OW-1:0];
                op_si   <= s_i[OW-1:0];
                issue_k <= KW'(1);
            end else if (state_q == ISSUE) begin
                issue_k <= (issue_k == KW'(LEN - 1)) ? '0 : issue_k + KW'(1);
            end
        end
    end

    // Accumulate tagged products and register the saturated result on the last one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r  <= '0;
            acc_i  <= '0;
            prod_k <= '0;
            y_r    <= '0;
            y_i    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (prod_vld) begin
                acc_r  <= sum_r;
                acc_i  <= sum_i;
                prod_k <= prod_last ? '0 : prod_k + KW'(1);
            end
            if (state_q == DRAIN && prod_last) begin
                y_r <= sat_r[N-1:0];
                y_i <= sat_i[N-1:0];
                ovf <= sat_r[N] | sat_i[N];
            end
        end
    end

endmodule

// File: tb/tb_cmult_dot_ctrl.sv
// Bench for cmult_dot_ctrl with behavioural cmult models at latency 1 and 3.
// Directed vectors with hand-computed sums, plus backpressure, back-to-back and reset sequences.
// The latency-3 instance is exercised separately with the nominal vector.
module tb_cmult_dot_ctrl;

    localparam int Q = 8;
    localparam int N = 16;
    localparam int LEN = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, ovf, busy;
    logic [63:0] h_r = '0, h_i = '0, s_r = '0, s_i = '0;
    logic [15:0] ar, ai, br, bi, pr, pi, y_r, y_i;

    logic        in_valid2 = 1'b0, out_ready2 = 1'b0;
    logic        in_ready2, out_valid2, ovf2, busy2;
    logic [15:0] ar2, ai2, br2, bi2, pr2, pi2, y_r2, y_i2;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_q[$];
    int hs_q[$];
    logic [32:0] res_q[$];
    logic [15:0] ar_tr[8];

    always #5 clk = ~clk;

    cmult_dot_ctrl #(.Q(Q), .N(N), .LEN(LEN), .MULT_LAT(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .h_r(h_r), .h_i(h_i), .s_r(s_r), .s_i(s_i),
        .ar(ar), .ai(ai), .br(br), .bi(bi), .pr(pr), .pi(pi),
        .out_valid(out_valid), .out_ready(out_ready),
        .y_r(y_r), .y_i(y_i), .ovf(ovf), .busy(busy)
    );

    cmult_dot_ctrl #(.Q(Q), .N(N), .LEN(LEN), .MULT_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .h_r(h_r), .h_i(h_i), .s_r(s_r), .s_i(s_i),
        .ar(ar2), .ai(ai2), .br(br2), .bi(bi2), .pr(pr2), .pi(pi2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .y_r(y_r2), .y_i(y_i2), .ovf(ovf2), .busy(busy2)
    );

    function automatic logic [31:0] cmul(input logic [15:0] a_r, a_i, b_r, b_i);
        longint re, im;
        re = (longint'($signed(a_r)) * longint'($signed(b_r))
            - longint'($signed(a_i)) * longint'($signed(b_i))) >>> Q;
        im = (longint'($signed(a_r)) * longint'($signed(b_i))
            + longint'($signed(a_i)) * longint'($signed(b_r))) >>> Q;
        return {re[15:0], im[15:0]};
    endfunction

    // Reference result {ovf, y_r, y_i} built from the same product model.
    function automatic logic [32:0] dot_ref(input logic [63:0] hr, hi, sr, si);
        int sum_r, sum_i;
        logic [31:0] p;
        logic [15:0] yr, yi;
        logic ov;
        sum_r = 0;
        sum_i = 0;
        ov = 1'b0;
        for (int k = 0; k < LEN; k++) begin
            p = cmul(hr[63-16*k -: 16], hi[63-16*k -: 16], sr[63-16*k -: 16], si[63-16*k -: 16]);
            sum_r += int'($signed(p[31:16]));
            sum_i += int'($signed(p[15:0]));
        end
        if (sum_r > 32767) begin yr = 16'h7fff; ov = 1'b1; end
        else if (sum_r < -32768) begin yr = 16'h8000; ov = 1'b1; end
        else yr = sum_r[15:0];
        if (sum_i > 32767) begin yi = 16'h7fff; ov = 1'b1; end
        else if (sum_i < -32768) begin yi = 16'h8000; ov = 1'b1; end
        else yi = sum_i[15:0];
        return {ov, yr, yi};
    endfunction

    // Behavioural cmult pipelines.
    logic [31:0] m1_q = '0;
    logic [31:0] m3_q[3] = '{default: '0};
    always @(posedge clk) begin
        m1_q    <= cmul(ar, ai, br, bi);
        m3_q[0] <= cmul(ar2, ai2, br2, bi2);
        m3_q[1] <= m3_q[0];
        m3_q[2] <= m3_q[1];
    end
    assign {pr, pi}   = m1_q;
    assign {pr2, pi2} = m3_q[2];

    // Handshake monitor for the latency-1 instance.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready) acc_q.push_back(cyc);
        if (out_valid && out_ready) begin
            hs_q.push_back(cyc);
            res_q.push_back({ovf, y_r, y_i});
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one vector, wait for the result, then complete the output handshake.
    task automatic run_vec(input logic [63:0] hr, hi, sr, si,
                           output logic [15:0] yr, output logic [15:0] yi,
                           output logic ov, output int lat);
        int n0;
        bit got;
        n0 = acc_q.size();
        h_r = hr; h_i = hi; s_r = sr; s_i = si;
        in_valid = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            step();
            if (acc_q.size() > n0) got = 1'b1;
        end
        in_valid = 1'b0;
        chk("accept", 64'(got), 64'd1);
        lat = 0;
        while (!out_valid && lat < 40) begin
            if (lat < 8) ar_tr[lat] = ar;
            step();
            lat++;
        end
        chk("out_valid seen", 64'(out_valid), 64'd1);
        yr = y_r; yi = y_i; ov = ovf;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [63:0] hr, hi, sr, si;
        logic [15:0] yr, yi;
        logic        ovf;
    } vec_t;

    vec_t tv[5];

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] yr, yi;
        logic ov;
        int lat, n0, nxt;
        int bb[3];
        logic [15:0] ar_exp[5];
        bit got;

        tv[0] = '{64'hffdd_0183_004d_0108, 64'h00c1_fff4_003c_fed8,
                  64'h0100_ff00_0100_ff00, 64'h0, 16'hfd9f, 16'h0231, 1'b0};
        tv[1] = '{64'h7000_7000_7000_7000, 64'h9000_9000_9000_9000,
                  64'h0100_0100_0100_0100, 64'h0, 16'h7fff, 16'h8000, 1'b1};
        tv[2] = '{64'h0100_0200_0300_0400, 64'h0,
                  64'h0100_0100_0100_0100, 64'h0080_0080_0080_0080, 16'h0a00, 16'h0500, 1'b0};
        tv[3] = '{64'h8000_8000_8000_8000, 64'h0,
                  64'h0100_0100_0100_0100, 64'h0, 16'h8000, 16'h0000, 1'b1};
        tv[4] = '{64'h0100_0100_0100_0100, 64'h0100_0100_0100_0100,
                  64'h0100_0100_0100_0100, 64'h0100_0100_0100_0100, 16'h0000, 16'h0800, 1'b0};
        ar_exp = '{16'hffdd, 16'h0183, 16'h004d, 16'h0108, 16'h0000};
        bb = '{2, 4, 1};

        // Reset state.
        rst = 1'b0;
        #12;
        chk("rst ar", 64'(ar), 64'd0);
        chk("rst ai", 64'(ai), 64'd0);
        chk("rst br", 64'(br), 64'd0);
        chk("rst bi", 64'(bi), 64'd0);
        chk("rst y_r", 64'(y_r), 64'd0);
        chk("rst y_i", 64'(y_i), 64'd0);
        chk("rst ovf", 64'(ovf), 64'd0);
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        rst = 1'b1;
        step();

        // Table of directed vectors.
        for (int i = 0; i < 5; i++) begin
            run_vec(tv[i].hr, tv[i].hi, tv[i].sr, tv[i].si, yr, yi, ov, lat);
            chk($sformatf("vec%0d y_r", i), 64'(yr), 64'(tv[i].yr));
            chk($sformatf("vec%0d y_i", i), 64'(yi), 64'(tv[i].yi));
            chk($sformatf("vec%0d ovf", i), 64'(ov), 64'(tv[i].ovf));
            chk($sformatf("vec%0d latency", i), 64'(lat), 64'd5);
            if (i == 0) begin
                for (int k = 0; k < 5; k++)
                    chk($sformatf("nominal ar[%0d]", k), 64'(ar_tr[k]), 64'(ar_exp[k]));
            end
        end

        // Backpressure: hold the result, offer a new vector meanwhile.
        h_r = tv[0].hr; h_i = tv[0].hi; s_r = tv[0].sr; s_i = tv[0].si;
        in_valid = 1'b1;
        n0 = acc_q.size();
        step();
        in_valid = 1'b0;
        chk("bp accept", 64'(acc_q.size()), 64'(n0 + 1));
        for (int t = 0; t < 20 && !out_valid; t++) step();
        chk("bp out_valid", 64'(out_valid), 64'd1);
        n0 = acc_q.size();
        h_r = tv[1].hr; h_i = tv[1].hi; s_r = tv[1].sr; s_i = tv[1].si;
        in_valid = 1'b1;
        for (int t = 0; t < 3; t++) begin
            step();
            chk("bp y_r hold", 64'(y_r), 64'hfd9f);
            chk("bp y_i hold", 64'(y_i), 64'h0231);
            chk("bp ovf hold", 64'(ovf), 64'd0);
            chk("bp in_ready", 64'(in_ready), 64'd0);
            chk("bp no accept", 64'(acc_q.size()), 64'(n0));
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        chk("bp accept after hs", 64'(acc_q.size()), 64'(n0 + 1));
        if (acc_q.size() > n0 && hs_q.size() > 0)
            chk("bp accept cycle", 64'(acc_q[$] - hs_q[$]), 64'd1);
        for (int t = 0; t < 20 && !out_valid; t++) step();
        chk("bp sat y_r", 64'(y_r), 64'h7fff);
        chk("bp sat y_i", 64'(y_i), 64'h8000);
        chk("bp sat ovf", 64'(ovf), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Back-to-back with both handshakes held high.
        acc_q.delete(); hs_q.delete(); res_q.delete();
        nxt = 0;
        h_r = tv[bb[0]].hr; h_i = tv[bb[0]].hi; s_r = tv[bb[0]].sr; s_i = tv[bb[0]].si;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int t = 0; t < 80 && hs_q.size() < 3; t++) begin
            step();
            if (acc_q.size() > nxt) begin
                nxt = acc_q.size();
                if (nxt < 3) begin
                    h_r = tv[bb[nxt]].hr; h_i = tv[bb[nxt]].hi;
                    s_r = tv[bb[nxt]].sr; s_i = tv[bb[nxt]].si;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b accepts", 64'(acc_q.size()), 64'd3);
        chk("b2b results", 64'(res_q.size()), 64'd3);
        if (acc_q.size() == 3 && res_q.size() == 3) begin
            chk("b2b gap01", 64'(acc_q[1] - acc_q[0]), 64'd7);
            chk("b2b gap12", 64'(acc_q[2] - acc_q[1]), 64'd7);
            chk("b2b hs delay", 64'(hs_q[0] - acc_q[0]), 64'd6);
            for (int i = 0; i < 3; i++)
                chk($sformatf("b2b res%0d", i), 64'(res_q[i]),
                    64'(dot_ref(tv[bb[i]].hr, tv[bb[i]].hi, tv[bb[i]].sr, tv[bb[i]].si)));
        end
        step();

        // Reset while element 2 is on the multiplier ports.
        h_r = tv[0].hr; h_i = tv[0].hi; s_r = tv[0].sr; s_i = tv[0].si;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("mid ar elem2", 64'(ar), 64'h004d);
        #2;
        rst = 1'b0;
        #1;
        chk("mid rst ar", 64'(ar), 64'd0);
        chk("mid rst br", 64'(br), 64'd0);
        chk("mid rst busy", 64'(busy), 64'd0);
        chk("mid rst in_ready", 64'(in_ready), 64'd1);
        chk("mid rst out_valid", 64'(out_valid), 64'd0);
        chk("mid rst y_r", 64'(y_r), 64'd0);
        chk("mid rst y_i", 64'(y_i), 64'd0);
        chk("mid rst ovf", 64'(ovf), 64'd0);
        #2;
        rst = 1'b1;
        step();
        run_vec(tv[0].hr, tv[0].hi, tv[0].sr, tv[0].si, yr, yi, ov, lat);
        chk("post rst y_r", 64'(yr), 64'hfd9f);
        chk("post rst y_i", 64'(yi), 64'h0231);
        chk("post rst ovf", 64'(ov), 64'd0);
        chk("post rst latency", 64'(lat), 64'd5);

        // Latency-3 instance with the nominal vector.
        h_r = tv[0].hr; h_i = tv[0].hi; s_r = tv[0].sr; s_i = tv[0].si;
        in_valid2 = 1'b1;
        step();
        in_valid2 = 1'b0;
        chk("lat3 accepted", 64'(busy2), 64'd1);
        lat = 0;
        while (!out_valid2 && lat < 40) begin
            step();
            lat++;
        end
        got = out_valid2;
        chk("lat3 out_valid", 64'(got), 64'd1);
        chk("lat3 latency", 64'(lat), 64'd7);
        chk("lat3 y_r", 64'(y_r2), 64'hfd9f);
        chk("lat3 y_i", 64'(y_i2), 64'h0231);
        chk("lat3 ovf", 64'(ovf2), 64'd0);
        out_ready2 = 1'b1;
        step();
        out_ready2 = 1'b0;
        chk("lat3 idle", 64'(busy2), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cmult_dot_ctrl.md
# cmult_dot_ctrl

Sequencer that computes one complex dot product of length LEN (a row of H times a column of S, Q8.8 fixed point) on a single shared `cmult` instance. It accepts a packed row/column vector pair over a valid/ready handshake and issues one element pair per cycle to the multiplier ports, most-significant element first. It tracks the multiplier latency, accumulates the returned products with saturation, and presents the complex sum on a valid/ready result port. It sits between the SOML decoder's matrix-operand buffers and the `cmult` datapath.

## Interface
- Q, 8, fractional bits (passed through to `cmult`; no rescaling here)
- N, 16, element width in bits (signed)
- LEN, 4, elements per dot product (≥2)
- MULT_LAT, 1, `cmult` latency in clock edges from `ar/ai/br/bi` to `pr/pi`
- AW, N+$clog2(LEN), internal accumulator width (localparam)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  operand vector valid
- in_ready  out  1  block idle, can accept a vector
- h_r, h_i  in  LEN*N  H row real/imag; element 0 = bits [LEN*N-1 -: N]
- s_r, s_i  in  LEN*N  S column real/imag; same packing
- ar, ai, br, bi  out  N  operands to `cmult`
- pr, pi  in  N  product from `cmult`
- out_valid  out  1  result valid
- out_ready  in  1  result consumer ready
- y_r, y_i  out  N  saturated dot-product result
- ovf  out  1  saturation occurred on y_r or y_i for this result
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE → ISSUE → DRAIN → DONE → IDLE.
- IDLE: `in_ready`=1 (combinational from state). On `in_valid && in_ready`, latch h_r/h_i/s_r/s_i into a local operand register and go to ISSUE. `in_valid` in any other state is ignored.
- ISSUE: issue counter k=0..LEN-1 drives element k onto the registered `ar/ai/br/bi`. A tag bit enters a MULT_LAT-deep valid shift register with each issue. After k=LEN-1, go to DRAIN.
- DRAIN: `ar/ai/br/bi` are driven to 0. The block waits until the LEN-th tagged product has been accumulated, then goes to DONE.
- Accumulation: when the shift-register output is 1, sign-extend `pr`/`pi` to AW. The first product of a vector loads the accumulator; later products add to it. AW is sized so no internal overflow is possible.
- Result: on entry to DONE, saturate each accumulator to the signed N-bit range [-2^(N-1), 2^(N-1)-1] and register it to `y_r`/`y_i`. `ovf` = either component was clipped. Assert `out_valid`.
- DONE: hold `y_r`, `y_i`, `ovf` and `out_valid` stable until `out_valid && out_ready`, then return to IDLE.
- No overlap between vectors: a new vector is accepted only in IDLE.

## Timing
- Reset values: `ar/ai/br/bi`=0, `y_r/y_i`=0, `ovf`=0, `out_valid`=0, `busy`=0, `in_ready`=1, state=IDLE, counters and valid shift register cleared.
- Input handshake at edge E0: element k is on `ar..bi` from edge E0+k to E0+k+1.
- Product k is sampled at edge E0+k+MULT_LAT+1.
- `out_valid` rises after edge E0+LEN+MULT_LAT, which is E0+5 at the defaults.
- With `out_ready` held high: output handshake at E0+LEN+MULT_LAT+1, and the next input is accepted at E0+LEN+MULT_LAT+2. Sustained period is LEN+MULT_LAT+2 cycles (7 at the defaults).
- Reset asserted mid-operation clears everything immediately. Products still in `cmult` from before reset are ignored because the valid shift register is cleared.
- `out_ready` high before `out_valid` has no effect.

## Test plan
- Nominal: h_r=ffdd_0183_004d_0108, h_i=00c1_fff4_003c_fed8, s_r=0100_ff00_0100_ff00, s_i=0 → y_r=fd9f, y_i=0231, ovf=0; `out_valid` high exactly 5 cycles after accept; operands appear on `ar/ai/br/bi` in order ffdd, 0183, 004d, 0108.
- Saturation: h_r=7000 ×4, h_i=9000 ×4, s_r=0100 ×4, s_i=0 → y_r=7fff, y_i=8000, ovf=1; the next clean vector gives ovf=0.
- Backpressure: hold `out_ready` low 3 cycles after `out_valid` → y_r/y_i/`ovf` stable, `in_ready`=0, and an offered `in_valid` is not accepted. After `out_ready` rises, the offered vector is accepted on the cycle after the output handshake.
- Back-to-back: `in_valid` and `out_ready` tied high with 3 distinct vectors → accepts spaced exactly 7 cycles apart; each result matches a reference sum of the `pr`/`pi` values it consumed.
- Reset mid-ISSUE: pull `rst` low while element 2 is issued → all outputs return to reset values asynchronously. After release, the nominal vector again gives fd9f/0231 with no contamination.
- MULT_LAT=3 build: nominal vector → same result, with `out_valid` rising 7 cycles after accept.
